// File: rtl/field_pack_ctrl_pkg.sv
// Shared types and sizing for the field packer: state encoding, field/byte
// counts and the default tail bits appended below field f.
package field_pack_ctrl_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    localparam int          FIELD_W      = 5;
    localparam int          NFIELDS      = 6;
    localparam int          NBYTES       = 4;
    localparam logic [1:0]  TAIL_DEFAULT = 2'b11;

endpackage

// File: rtl/field_pack_ctrl_if.sv
// Field input stream and byte output stream of the packer.
// Handshake: a beat moves on a rising clk edge where valid && ready; a raised
// valid holds, with its data stable, until that beat moves; valid never
// depends combinationally on the matching ready.
interface field_pack_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       in_first;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid, in_data, in_first, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_first, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/field_pack_ctrl_concat32.sv
// Combinational concatenation of six 5-bit fields plus tail bits into a
// 32-bit word, split into bytes w (MSB) through z (LSB).
module field_concat32
    import field_pack_ctrl_pkg::*;
#(
    parameter logic [1:0] TAIL = TAIL_DEFAULT
) (
    input  logic [FIELD_W-1:0] a_i,
    input  logic [FIELD_W-1:0] b_i,
    input  logic [FIELD_W-1:0] c_i,
    input  logic [FIELD_W-1:0] d_i,
    input  logic [FIELD_W-1:0] e_i,
    input  logic [FIELD_W-1:0] f_i,
    output logic [7:0]         w_o,
    output logic [7:0]         x_o,
    output logic [7:0]         y_o,
    output logic [7:0]         z_o
);
    logic [31:0] word;

    assign word = {a_i, b_i, c_i, d_i, e_i, f_i, TAIL};
    assign {w_o, x_o, y_o, z_o} = word;
endmodule

// File: rtl/field_pack_ctrl.sv
// Sequencer: gathers six fields from the input stream, then emits the packed
// 32-bit word as four bytes; the two phases never overlap.
module field_pack_ctrl
    import field_pack_ctrl_pkg::*;
#(
    parameter logic [1:0] TAIL  = TAIL_DEFAULT,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    field_pack_ctrl_if.slave bus,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err,
    output logic             busy,
    output state_e           state_dbg_o
);
    state_e             state_q, state_d;
    logic [2:0]         fidx_q, fidx_d;
    logic [1:0]         bidx_q, bidx_d;
    logic [FIELD_W-1:0] field_q [NFIELDS];
    logic [FIELD_W-1:0] field_d [NFIELDS];
    logic [7:0]         byte_q  [NBYTES];
    logic [7:0]         byte_d  [NBYTES];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [7:0]         w, x, y, z;

    // Field f feeds the concatenation straight from the bus so the word is
    // ready to latch on the same edge that accepts f.
    field_concat32 #(.TAIL(TAIL)) u_concat (
        .a_i(field_q[0]), .b_i(field_q[1]), .c_i(field_q[2]),
        .d_i(field_q[3]), .e_i(field_q[4]), .f_i(bus.in_data),
        .w_o(w), .x_o(x), .y_o(y), .z_o(z)
    );

    always_comb begin
        state_d = state_q;
        fidx_d  = fidx_q;
        bidx_d  = bidx_q;
        field_d = field_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.in_valid) begin
                    if (bus.in_first && fidx_q != 3'd0) begin
                        field_d[0] = bus.in_data;
                        fidx_d     = 3'd1;
                        err_d      = 1'b1;
                    end else begin
                        field_d[fidx_q] = bus.in_data;
                        fidx_d          = fidx_q + 3'd1;
                        if (fidx_q == 3'(NFIELDS - 1)) begin
                            state_d   = EMIT;
                            bidx_d    = 2'd0;
                            byte_d[0] = w;
                            byte_d[1] = x;
                            byte_d[2] = y;
                            byte_d[3] = z;
                        end
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'(NBYTES - 1)) begin
                        state_d = COLLECT;
                        fidx_d  = 3'd0;
                        bidx_d  = 2'd0;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            fidx_q  <= 3'd0;
            bidx_q  <= 2'd0;
            field_q <= '{default: '0};
            byte_q  <= '{default: '0};
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fidx_q  <= fidx_d;
            bidx_q  <= bidx_d;
            field_q <= field_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = (state_q == EMIT) ? byte_q[bidx_q] : 8'h00;
    assign busy          = (state_q == EMIT);
    assign frame_cnt     = cnt_q;
    assign err           = err_q;
    assign state_dbg_o   = state_q;
endmodule

// File: doc/field_pack_ctrl.md
Name: field_pack_ctrl

Overview:
Sequencer wrapped around the 6x5-bit-field concatenation datapath. Collects six 5-bit fields serially over a valid/ready input stream and forms the 32-bit word {a,b,c,d,e,f,TAIL}. Emits that word as four bytes w,x,y,z in order over a valid/ready output stream. Sits between a narrow field producer and a byte-wide consumer; one frame is six fields in and four bytes out.

Parameters:
TAIL, 2'b11, constant 2 LSBs appended after field f.
CNT_W, 8, width of the frame counter.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  field available on in_data.
in_ready  output  1  block accepts a field this cycle.
in_data  input  5  field value; arrival order a,b,c,d,e,f.
in_first  input  1  qualifies in_data as field a (start of frame).
out_valid  output  1  byte available on out_data.
out_ready  input  1  consumer accepts the byte.
out_data  output  8  byte; order w=word[31:24], x=[23:16], y=[15:8], z=[7:0].
frame_cnt  output  CNT_W  completed frames (z accepted), wraps 2^CNT_W-1 -> 0.
err  output  1  one-cycle pulse: partial frame dropped.
busy  output  1  high while in EMIT.

Behaviour:
- Reset (async, immediate): state=COLLECT, fidx=0, bidx=0, field regs a..f=0, in_ready=1, out_valid=0, out_data=0, frame_cnt=0, err=0, busy=0.
- Transfer rules: input transfer = in_valid&&in_ready; output transfer = out_valid&&out_ready. out_valid, once high, stays high with out_data stable until the transfer completes. out_valid never depends combinationally on out_ready.
- COLLECT: in_ready=1, out_valid=0.
  - Each input transfer stores in_data into field[fidx], then fidx++.
  - in_first on a transfer with fidx!=0: drop the partial frame, store the field as a, set fidx=1, pulse err next cycle.
  - in_first with fidx==0: normal. Missing in_first on field a: accepted, no error.
  - On the transfer of field f (fidx==5): next cycle state=EMIT, bidx=0, word latched from the concat datapath, out_valid=1, out_data=w. Latency is 1 cycle from the f transfer to the w byte being presented.
- EMIT: in_ready=0, so in_valid and in_first are ignored. busy=1.
  - Each output transfer: bidx++ and out_data advances to the next byte in the next cycle.
  - On the transfer of z (bidx==3): next cycle state=COLLECT, fidx=0, out_valid=0, in_ready=1, frame_cnt++ (wraps).
  - There is no overlap between the EMIT of one frame and the COLLECT of the next; at full throughput a frame takes 10 cycles.
- Reset mid-operation: all state cleared; partial frame or unsent bytes discarded; frame_cnt not incremented; err not pulsed.
- Only two states exist: COLLECT and EMIT. fidx is 3 bits, legal 0..5. bidx is 2 bits, 0..3.

Decomposition:
- Shared package: state enum {COLLECT, EMIT}, FIELD_W=5, NFIELDS=6, NBYTES=4, default TAIL.
- One sub-module, field_concat32: purely combinational. Inputs a..f and TAIL; outputs w,x,y,z. The controller instantiates it and registers its outputs on entry to EMIT.

Test Plan:
- Reset then frame a..f=00,00,00,00,00,01 with out_ready=1 -> bytes 00,00,00,07; frame_cnt=1; err never high.
- Frame a..f=12,1F,05,08,0D,02 -> bytes 97,CA,86,8B in order. out_valid rises exactly 1 cycle after the f transfer; in_ready=0 for 4 cycles.
- Same frame with out_ready toggling 1,0,0,1,0,1,1 -> out_data holds while stalled; 4 bytes delivered exactly once; no loss or duplication.
- Send 3 fields, then in_first with 0C followed by 0E,02,07,04,04 -> err pulses once; output bytes equal those of frame {0C,0E,02,07,04,04} only.
- Assert rst during EMIT after byte x -> out_valid=0 immediately; frame_cnt=0. The next full frame is emitted correctly from w.
- Run 256 back-to-back frames -> frame_cnt wraps to 0; throughput is 10 cycles per frame with both sides always ready.
